// File: rtl/mem_stage_cache.sv
// MEM stage of the 16-bit MIPS: direct-mapped write-through / no-write-allocate
// cache in front of an off-chip req/ack memory port, producing the MEM/WB register.
module mem_stage_cache #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [15:0] ex_alu_result,
  input  logic [15:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write_en,
  input  logic [2:0]  ex_reg_dest,
  output logic [36:0] pipeline_reg_out,
  output logic        stall,
  output logic [2:0]  mem_op_dest,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned LINES    = 2 ** INDEX_BITS;
  localparam int unsigned TAG_BITS = 16 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tags  [LINES];
  logic [15:0]           lines [LINES];
  logic [15:0]           fill_data;

  logic [INDEX_BITS-1:0] idx;
  logic [INDEX_BITS-1:0] widx;
  logic                  hit;
  logic                  wr_hit;
  logic                  is_load;
  logic                  is_store;
  logic                  wb_en;

  assign idx      = ex_alu_result[INDEX_BITS-1:0];
  assign widx     = mem_addr[INDEX_BITS-1:0];
  assign hit      = valid[idx] & (tags[idx] == ex_alu_result[15:INDEX_BITS]);
  assign wr_hit   = valid[widx] & (tags[widx] == mem_addr[15:INDEX_BITS]);
  // Read+write together is a store, so a load requires the write bit clear.
  assign is_store = ex_valid & ex_mem_write;
  assign is_load  = ex_valid & ex_mem_read & ~ex_mem_write;
  assign wb_en    = ex_valid & ex_reg_write_en;

  assign mem_op_dest = wb_en ? ex_reg_dest : 3'd0;

  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:             stall = is_store | (is_load & ~hit);
      RD_WAIT, WR_WAIT: stall = 1'b1;
      default:          stall = 1'b0;
    endcase
  end

  // Tag/data arrays carry no reset; only the valid bits do. Gating on rst
  // keeps an abandoned access from writing the line.
  always_ff @(posedge clk) begin
    if (rst && mem_ack) begin
      if (state == RD_WAIT) begin
        tags[widx]  <= mem_addr[15:INDEX_BITS];
        lines[widx] <= mem_rdata;
      end else if (state == WR_WAIT && wr_hit) begin
        lines[widx] <= mem_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      pipeline_reg_out <= '0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      valid            <= '0;
      fill_data        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_store) begin
            pipeline_reg_out <= '0;
            mem_req          <= 1'b1;
            mem_we           <= 1'b1;
            mem_addr         <= ex_alu_result;
            mem_wdata        <= ex_store_data;
            state            <= WR_WAIT;
          end else if (is_load && !hit) begin
            pipeline_reg_out <= '0;
            mem_req          <= 1'b1;
            mem_we           <= 1'b0;
            mem_addr         <= ex_alu_result;
            state            <= RD_WAIT;
          end else if (!ex_valid) begin
            pipeline_reg_out <= '0;
          end else begin
            pipeline_reg_out <= {ex_alu_result, is_load ? lines[idx] : 16'h0000,
                                 wb_en, ex_reg_dest, is_load};
          end
        end
        RD_WAIT: begin
          pipeline_reg_out <= '0;
          if (mem_ack) begin
            mem_req     <= 1'b0;
            fill_data   <= mem_rdata;
            valid[widx] <= 1'b1;
            state       <= DONE;
          end
        end
        WR_WAIT: begin
          pipeline_reg_out <= '0;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          pipeline_reg_out <= {ex_alu_result, is_load ? fill_data : 16'h0000,
                               wb_en, ex_reg_dest, is_load};
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
